// File: rtl/sc_microsequencer_pkg.sv
// Shared constants for the microsequencer: FSM state codes, branch conditions
// and the microword field geometry derived from the datapath select widths.
package sc_microsequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_BRANCH = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [2:0] COND_NEXT = 3'd0;
  localparam logic [2:0] COND_JMP  = 3'd1;
  localparam logic [2:0] COND_JZ   = 3'd2;
  localparam logic [2:0] COND_JN   = 3'd3;
  localparam logic [2:0] COND_JC   = 3'd4;
  localparam logic [2:0] COND_JV   = 3'd5;
  localparam logic [2:0] COND_JNZ  = 3'd6;
  localparam logic [2:0] COND_HALT = 3'd7;

  localparam int COND_W = 3;

  // Shifter clear/load are active-low, so the idle level is 1.
  localparam logic SH_CTRL_INACTIVE = 1'b1;

  // Field indices, LSB first; the microword is laid out in this order.
  localparam int F_SHSEL  = 0;
  localparam int F_SHLD   = 1;
  localparam int F_SHCLR  = 2;
  localparam int F_ALU    = 3;
  localparam int F_MUXB   = 4;
  localparam int F_MUXA   = 5;
  localparam int F_LDSEL  = 6;
  localparam int F_CLRSEL = 7;
  localparam int F_TARGET = 8;
  localparam int F_COND   = 9;
  localparam int F_COUNT  = 10;

  function automatic int field_width(input int f, input int addr_w, input int dec_w,
                                     input int mux_w, input int alu_w, input int sh_w);
    int w;
    w = 0;
    case (f)
      F_SHSEL:           w = sh_w;
      F_SHLD, F_SHCLR:   w = 1;
      F_ALU:             w = alu_w;
      F_MUXB, F_MUXA:    w = mux_w;
      F_LDSEL, F_CLRSEL: w = dec_w;
      F_TARGET:          w = addr_w;
      F_COND:            w = COND_W;
      default:           w = 0;
    endcase
    return w;
  endfunction

  function automatic int field_lsb(input int f, input int addr_w, input int dec_w,
                                   input int mux_w, input int alu_w, input int sh_w);
    int lsb;
    lsb = 0;
    for (int i = 0; i < f; i++) lsb += field_width(i, addr_w, dec_w, mux_w, alu_w, sh_w);
    return lsb;
  endfunction

  function automatic int uword_width(input int addr_w, input int dec_w, input int mux_w,
                                     input int alu_w, input int sh_w);
    return field_lsb(F_COUNT, addr_w, dec_w, mux_w, alu_w, sh_w);
  endfunction

endpackage

// File: rtl/sc_microsequencer_if.sv
// Control/handshake bundle between the system and the microsequencer.
interface sc_microsequencer_if #(
  parameter int ADDR_W  = 4,
  parameter int DEC_W   = 3,
  parameter int MUX_W   = 3,
  parameter int ALU_W   = 4,
  parameter int SH_W    = 2,
  parameter int UWORD_W = 27
);
  logic               SC_MICROSEQUENCER_start_In;
  logic [ADDR_W-1:0]  SC_MICROSEQUENCER_startaddr_InBUS;
  logic               SC_MICROSEQUENCER_abort_In;
  logic               SC_MICROSEQUENCER_progwrite_In;
  logic [ADDR_W-1:0]  SC_MICROSEQUENCER_progaddr_InBUS;
  logic [UWORD_W-1:0] SC_MICROSEQUENCER_progdata_InBUS;
  logic               SC_MICROSEQUENCER_overflow_InLow;
  logic               SC_MICROSEQUENCER_carry_InLow;
  logic               SC_MICROSEQUENCER_negative_InLow;
  logic               SC_MICROSEQUENCER_zero_InLow;
  logic [DEC_W-1:0]   SC_MICROSEQUENCER_decoderclearselection_OutBUS;
  logic [DEC_W-1:0]   SC_MICROSEQUENCER_decoderloadselection_OutBUS;
  logic [MUX_W-1:0]   SC_MICROSEQUENCER_muxselectionBUSA_OutBUS;
  logic [MUX_W-1:0]   SC_MICROSEQUENCER_muxselectionBUSB_OutBUS;
  logic [ALU_W-1:0]   SC_MICROSEQUENCER_aluselection_OutBUS;
  logic               SC_MICROSEQUENCER_regSHIFTERclear_OutLow;
  logic               SC_MICROSEQUENCER_regSHIFTERload_OutLow;
  logic [SH_W-1:0]    SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS;
  logic               SC_MICROSEQUENCER_busy_Out;
  logic               SC_MICROSEQUENCER_done_Out;
  logic               SC_MICROSEQUENCER_error_Out;
  logic [ADDR_W-1:0]  SC_MICROSEQUENCER_pc_OutBUS;

  modport master (
    output SC_MICROSEQUENCER_start_In, SC_MICROSEQUENCER_startaddr_InBUS,
           SC_MICROSEQUENCER_abort_In, SC_MICROSEQUENCER_progwrite_In,
           SC_MICROSEQUENCER_progaddr_InBUS, SC_MICROSEQUENCER_progdata_InBUS,
           SC_MICROSEQUENCER_overflow_InLow, SC_MICROSEQUENCER_carry_InLow,
           SC_MICROSEQUENCER_negative_InLow, SC_MICROSEQUENCER_zero_InLow,
    input  SC_MICROSEQUENCER_decoderclearselection_OutBUS,
           SC_MICROSEQUENCER_decoderloadselection_OutBUS,
           SC_MICROSEQUENCER_muxselectionBUSA_OutBUS, SC_MICROSEQUENCER_muxselectionBUSB_OutBUS,
           SC_MICROSEQUENCER_aluselection_OutBUS, SC_MICROSEQUENCER_regSHIFTERclear_OutLow,
           SC_MICROSEQUENCER_regSHIFTERload_OutLow, SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS,
           SC_MICROSEQUENCER_busy_Out, SC_MICROSEQUENCER_done_Out,
           SC_MICROSEQUENCER_error_Out, SC_MICROSEQUENCER_pc_OutBUS
  );

  modport slave (
    input  SC_MICROSEQUENCER_start_In, SC_MICROSEQUENCER_startaddr_InBUS,
           SC_MICROSEQUENCER_abort_In, SC_MICROSEQUENCER_progwrite_In,
           SC_MICROSEQUENCER_progaddr_InBUS, SC_MICROSEQUENCER_progdata_InBUS,
           SC_MICROSEQUENCER_overflow_InLow, SC_MICROSEQUENCER_carry_InLow,
           SC_MICROSEQUENCER_negative_InLow, SC_MICROSEQUENCER_zero_InLow,
    output SC_MICROSEQUENCER_decoderclearselection_OutBUS,
           SC_MICROSEQUENCER_decoderloadselection_OutBUS,
           SC_MICROSEQUENCER_muxselectionBUSA_OutBUS, SC_MICROSEQUENCER_muxselectionBUSB_OutBUS,
           SC_MICROSEQUENCER_aluselection_OutBUS, SC_MICROSEQUENCER_regSHIFTERclear_OutLow,
           SC_MICROSEQUENCER_regSHIFTERload_OutLow, SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS,
           SC_MICROSEQUENCER_busy_Out, SC_MICROSEQUENCER_done_Out,
           SC_MICROSEQUENCER_error_Out, SC_MICROSEQUENCER_pc_OutBUS
  );
endinterface

// File: rtl/sc_microsequencer_uprogram_ram.sv
// Micro-program store: synchronous write, asynchronous read, single address space.
module sc_uprogram_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 27,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose; a loaded program must
  // survive a sequencer reset, and a reset would also block RAM inference.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sc_microsequencer.sv
// Programmable microsequencer: fetch/exec/branch loop over a loadable
// micro-program, driving the datapath control buses one EXEC cycle per word.
module sc_microsequencer
  import sc_microsequencer_pkg::*;
#(
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int UPROG_DEPTH                    = 16,
  parameter int MAX_STEPS                      = 255
) (
  input logic                SC_MICROSEQUENCER_CLOCK_50,
  input logic                SC_MICROSEQUENCER_RESET_InLow,
  sc_microsequencer_if.slave sq
);
  localparam int DEC_W   = DATAWIDTH_DECODER_SELECTION;
  localparam int MUX_W   = DATAWIDTH_MUX_SELECTION;
  localparam int ALU_W   = DATAWIDTH_ALU_SELECTION;
  localparam int SH_W    = DATAWIDTH_REGSHIFTER_SELECTION;
  localparam int ADDR_W  = $clog2(UPROG_DEPTH);
  localparam int STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int UWORD_W = uword_width(ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);

  localparam int SHSEL_LSB  = field_lsb(F_SHSEL,  ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int SHLD_LSB   = field_lsb(F_SHLD,   ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int SHCLR_LSB  = field_lsb(F_SHCLR,  ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int ALU_LSB    = field_lsb(F_ALU,    ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int MUXB_LSB   = field_lsb(F_MUXB,   ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int MUXA_LSB   = field_lsb(F_MUXA,   ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int LDSEL_LSB  = field_lsb(F_LDSEL,  ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int CLRSEL_LSB = field_lsb(F_CLRSEL, ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int TARGET_LSB = field_lsb(F_TARGET, ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);
  localparam int COND_LSB   = field_lsb(F_COND,   ADDR_W, DEC_W, MUX_W, ALU_W, SH_W);

  logic clk, rst_n;
  assign clk   = SC_MICROSEQUENCER_CLOCK_50;
  assign rst_n = SC_MICROSEQUENCER_RESET_InLow;

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [UWORD_W-1:0] ir_q, ir_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               error_q, error_d;

  logic [UWORD_W-1:0] rd_word;
  logic               running, abort_now, prog_we, taken;
  logic [2:0]         ir_cond;
  logic [ADDR_W-1:0]  ir_target;

  assign running   = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_BRANCH);
  assign abort_now = running && sq.SC_MICROSEQUENCER_abort_In;
  assign prog_we   = sq.SC_MICROSEQUENCER_progwrite_In && (state_q == ST_IDLE);
  assign ir_cond   = ir_q[COND_LSB +: COND_W];
  assign ir_target = ir_q[TARGET_LSB +: ADDR_W];

  sc_uprogram_ram #(.DEPTH(UPROG_DEPTH), .WIDTH(UWORD_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (prog_we),
    .waddr (sq.SC_MICROSEQUENCER_progaddr_InBUS),
    .wdata (sq.SC_MICROSEQUENCER_progdata_InBUS),
    .raddr (pc_q),
    .rdata (rd_word)
  );

  // Flag lines are active-low: a 0 means the condition holds.
  always_comb begin
    taken = 1'b0;
    case (ir_cond)
      COND_JMP: taken = 1'b1;
      COND_JZ:  taken = !sq.SC_MICROSEQUENCER_zero_InLow;
      COND_JN:  taken = !sq.SC_MICROSEQUENCER_negative_InLow;
      COND_JC:  taken = !sq.SC_MICROSEQUENCER_carry_InLow;
      COND_JV:  taken = !sq.SC_MICROSEQUENCER_overflow_InLow;
      COND_JNZ: taken = sq.SC_MICROSEQUENCER_zero_InLow;
      default:  taken = 1'b0;
    endcase
  end

  // NOTE: every _d starts from its _q value so no path leaves a variable
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    step_d  = step_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (sq.SC_MICROSEQUENCER_start_In) begin
          pc_d    = sq.SC_MICROSEQUENCER_startaddr_InBUS;
          step_d  = '0;
          error_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_d    = rd_word;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        step_d  = step_q + STEP_W'(1);
        state_d = ST_BRANCH;
      end
      ST_BRANCH: begin
        if (ir_cond == COND_HALT) begin
          state_d = ST_DONE;
        end else if (step_q == STEP_W'(MAX_STEPS)) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          pc_d    = taken ? ir_target : pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort wins over whatever the current state would have done.
    if (abort_now) begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      step_d  = step_q;
      error_d = 1'b1;
      state_d = ST_DONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      step_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      step_q  <= step_d;
      error_q <= error_d;
    end
  end

  logic exec_drive;
  assign exec_drive = (state_q == ST_EXEC) && !abort_now;

  always_comb begin
    sq.SC_MICROSEQUENCER_decoderclearselection_OutBUS    = '1;
    sq.SC_MICROSEQUENCER_decoderloadselection_OutBUS     = '1;
    sq.SC_MICROSEQUENCER_muxselectionBUSA_OutBUS         = '0;
    sq.SC_MICROSEQUENCER_muxselectionBUSB_OutBUS         = '0;
    sq.SC_MICROSEQUENCER_aluselection_OutBUS             = '0;
    sq.SC_MICROSEQUENCER_regSHIFTERclear_OutLow          = SH_CTRL_INACTIVE;
    sq.SC_MICROSEQUENCER_regSHIFTERload_OutLow           = SH_CTRL_INACTIVE;
    sq.SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS = '0;
    if (exec_drive) begin
      sq.SC_MICROSEQUENCER_decoderclearselection_OutBUS    = ir_q[CLRSEL_LSB +: DEC_W];
      sq.SC_MICROSEQUENCER_decoderloadselection_OutBUS     = ir_q[LDSEL_LSB +: DEC_W];
      sq.SC_MICROSEQUENCER_muxselectionBUSA_OutBUS         = ir_q[MUXA_LSB +: MUX_W];
      sq.SC_MICROSEQUENCER_muxselectionBUSB_OutBUS         = ir_q[MUXB_LSB +: MUX_W];
      sq.SC_MICROSEQUENCER_aluselection_OutBUS             = ir_q[ALU_LSB +: ALU_W];
      sq.SC_MICROSEQUENCER_regSHIFTERclear_OutLow          = ir_q[SHCLR_LSB];
      sq.SC_MICROSEQUENCER_regSHIFTERload_OutLow           = ir_q[SHLD_LSB];
      sq.SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS = ir_q[SHSEL_LSB +: SH_W];
    end
  end

  assign sq.SC_MICROSEQUENCER_busy_Out  = running;
  assign sq.SC_MICROSEQUENCER_done_Out  = (state_q == ST_DONE);
  assign sq.SC_MICROSEQUENCER_error_Out = error_q;
  assign sq.SC_MICROSEQUENCER_pc_OutBUS = pc_q;

endmodule

// File: tb/tb_sc_microsequencer.sv
// Bench for sc_microsequencer: an instruction-level interpreter expands each
// run into an expected per-cycle trace that a negedge process compares against.
module tb_sc_microsequencer;

  localparam int MAX_STEPS = 5;

  typedef struct packed {
    logic [2:0] cond;
    logic [3:0] target;
    logic [2:0] clr;
    logic [2:0] ld;
    logic [2:0] muxa;
    logic [2:0] muxb;
    logic [3:0] alu;
    logic       shclr_n;
    logic       shld_n;
    logic [1:0] shsel;
  } uword_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  pc;
    logic [19:0] ctrl;
  } exp_t;

  localparam logic [19:0] CTRL_OFF = {3'h7, 3'h7, 3'h0, 3'h0, 4'h0, 1'b1, 1'b1, 2'h0};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sc_microsequencer_if #(.ADDR_W(4), .DEC_W(3), .MUX_W(3), .ALU_W(4), .SH_W(2), .UWORD_W(27)) sq ();

  sc_microsequencer #(
    .DATAWIDTH_DECODER_SELECTION   (3),
    .DATAWIDTH_MUX_SELECTION       (3),
    .DATAWIDTH_ALU_SELECTION       (4),
    .DATAWIDTH_REGSHIFTER_SELECTION(2),
    .UPROG_DEPTH                   (16),
    .MAX_STEPS                     (MAX_STEPS)
  ) dut (
    .SC_MICROSEQUENCER_CLOCK_50    (clk),
    .SC_MICROSEQUENCER_RESET_InLow (rst_n),
    .sq                            (sq)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  uword_t mem_m [16];
  exp_t   exp_q [$];
  exp_t   idle_exp;
  exp_t   cur;
  bit     chk_en = 1'b0;
  int     cyc, done_cyc;
  bit     done_seen;
  int     alu_cyc [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic uword_t mkw(input logic [2:0] cond, input logic [3:0] target,
                                 input logic [2:0] clr, input logic [2:0] ld,
                                 input logic [2:0] muxa, input logic [2:0] muxb,
                                 input logic [3:0] alu, input logic shclr_n,
                                 input logic shld_n, input logic [1:0] shsel);
    uword_t w;
    w.cond = cond; w.target = target; w.clr = clr; w.ld = ld; w.muxa = muxa;
    w.muxb = muxb; w.alu = alu; w.shclr_n = shclr_n; w.shld_n = shld_n; w.shsel = shsel;
    return w;
  endfunction

  function automatic logic [19:0] ctrl_of(input uword_t w);
    return {w.clr, w.ld, w.muxa, w.muxb, w.alu, w.shclr_n, w.shld_n, w.shsel};
  endfunction

  function automatic bit is_taken(input uword_t w);
    case (w.cond)
      3'd1:    return 1'b1;
      3'd2:    return sq.SC_MICROSEQUENCER_zero_InLow == 1'b0;
      3'd3:    return sq.SC_MICROSEQUENCER_negative_InLow == 1'b0;
      3'd4:    return sq.SC_MICROSEQUENCER_carry_InLow == 1'b0;
      3'd5:    return sq.SC_MICROSEQUENCER_overflow_InLow == 1'b0;
      3'd6:    return sq.SC_MICROSEQUENCER_zero_InLow == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void add(input logic b, input logic d, input logic e,
                              input logic [3:0] pc, input logic [19:0] ctrl);
    exp_q.push_back({b, d, e, pc, ctrl});
  endfunction

  // Interpreter: every instruction is three busy cycles (only the middle one
  // drives controls), then a single done cycle once the run ends.
  task automatic build_trace(input logic [3:0] sa, input int abort_at);
    logic [3:0] pc;
    int steps, idx;
    uword_t w;
    pc = sa; steps = 0; idx = 0;
    for (int n = 0; n < 64; n++) begin
      w = mem_m[pc];
      for (int ph = 0; ph < 3; ph++) begin
        add(1'b1, 1'b0, 1'b0, pc, (ph == 1 && idx != abort_at) ? ctrl_of(w) : CTRL_OFF);
        if (idx == abort_at) begin
          add(1'b0, 1'b1, 1'b1, pc, CTRL_OFF);
          return;
        end
        idx++;
      end
      steps++;
      if (w.cond == 3'd7) begin
        add(1'b0, 1'b1, 1'b0, pc, CTRL_OFF);
        return;
      end
      if (steps == MAX_STEPS) begin
        add(1'b0, 1'b1, 1'b1, pc, CTRL_OFF);
        return;
      end
      pc = is_taken(w) ? w.target : pc + 4'd1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_exp;
      cyc++;
      if (sq.SC_MICROSEQUENCER_done_Out === 1'b1 && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (sq.SC_MICROSEQUENCER_aluselection_OutBUS != 4'h0 &&
          alu_cyc[sq.SC_MICROSEQUENCER_aluselection_OutBUS] == 0)
        alu_cyc[sq.SC_MICROSEQUENCER_aluselection_OutBUS] = cyc;
      check("status", {29'd0, sq.SC_MICROSEQUENCER_busy_Out, sq.SC_MICROSEQUENCER_done_Out,
                       sq.SC_MICROSEQUENCER_error_Out}, {29'd0, cur.busy, cur.done, cur.error});
      check("pc", {28'd0, sq.SC_MICROSEQUENCER_pc_OutBUS}, {28'd0, cur.pc});
      check("ctrl", {12'd0, sq.SC_MICROSEQUENCER_decoderclearselection_OutBUS,
                     sq.SC_MICROSEQUENCER_decoderloadselection_OutBUS,
                     sq.SC_MICROSEQUENCER_muxselectionBUSA_OutBUS,
                     sq.SC_MICROSEQUENCER_muxselectionBUSB_OutBUS,
                     sq.SC_MICROSEQUENCER_aluselection_OutBUS,
                     sq.SC_MICROSEQUENCER_regSHIFTERclear_OutLow,
                     sq.SC_MICROSEQUENCER_regSHIFTERload_OutLow,
                     sq.SC_MICROSEQUENCER_regSHIFTERshiftselection_OutBUS}, {12'd0, cur.ctrl});
      if (cur.done) idle_exp = {1'b0, 1'b0, cur.error, cur.pc, CTRL_OFF};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic prog(input logic [3:0] a, input uword_t w);
    sq.SC_MICROSEQUENCER_progwrite_In   = 1'b1;
    sq.SC_MICROSEQUENCER_progaddr_InBUS = a;
    sq.SC_MICROSEQUENCER_progdata_InBUS = w;
    tick();
    sq.SC_MICROSEQUENCER_progwrite_In = 1'b0;
    mem_m[a] = w;
  endtask

  task automatic launch(input logic [3:0] sa, input int abort_at, input bit wr,
                        input logic [3:0] wa, input uword_t wd);
    sq.SC_MICROSEQUENCER_start_In        = 1'b1;
    sq.SC_MICROSEQUENCER_startaddr_InBUS = sa;
    sq.SC_MICROSEQUENCER_progwrite_In    = wr;
    sq.SC_MICROSEQUENCER_progaddr_InBUS  = wa;
    sq.SC_MICROSEQUENCER_progdata_InBUS  = wd;
    tick();
    sq.SC_MICROSEQUENCER_start_In     = 1'b0;
    sq.SC_MICROSEQUENCER_progwrite_In = 1'b0;
    if (wr) mem_m[wa] = wd;
    cyc = 0; done_seen = 1'b0; done_cyc = 0;
    foreach (alu_cyc[i]) alu_cyc[i] = 0;
    build_trace(sa, abort_at);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic run(input logic [3:0] sa, input int abort_at);
    launch(sa, abort_at, 1'b0, 4'h0, '0);
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
      sq.SC_MICROSEQUENCER_abort_In = 1'b1;
      tick();
      sq.SC_MICROSEQUENCER_abort_In = 1'b0;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0;
    sq.SC_MICROSEQUENCER_start_In        = 1'b0;
    sq.SC_MICROSEQUENCER_startaddr_InBUS = '0;
    sq.SC_MICROSEQUENCER_abort_In        = 1'b0;
    sq.SC_MICROSEQUENCER_progwrite_In    = 1'b0;
    sq.SC_MICROSEQUENCER_progaddr_InBUS  = '0;
    sq.SC_MICROSEQUENCER_progdata_InBUS  = '0;
    sq.SC_MICROSEQUENCER_overflow_InLow  = 1'b1;
    sq.SC_MICROSEQUENCER_carry_InLow     = 1'b1;
    sq.SC_MICROSEQUENCER_negative_InLow  = 1'b1;
    sq.SC_MICROSEQUENCER_zero_InLow      = 1'b1;
    foreach (mem_m[i]) mem_m[i] = '0;
    repeat (2) tick();
    rst_n    = 1'b1;
    idle_exp = {1'b0, 1'b0, 1'b0, 4'h0, CTRL_OFF};
    check("rst_busy", sq.SC_MICROSEQUENCER_busy_Out, 0);
    check("rst_done", sq.SC_MICROSEQUENCER_done_Out, 0);
    check("rst_err", sq.SC_MICROSEQUENCER_error_Out, 0);
    check("rst_pc", sq.SC_MICROSEQUENCER_pc_OutBUS, 0);
    check("rst_clr", sq.SC_MICROSEQUENCER_decoderclearselection_OutBUS, 3'h7);
    check("rst_shld", sq.SC_MICROSEQUENCER_regSHIFTERload_OutLow, 1);
    chk_en = 1'b1;

    // Two-word program: EXEC cycles at 2 and 5, done at 7.
    prog(4'd0, mkw(3'd0, 4'd0, 3'h7, 3'h0, 3'h1, 3'h2, 4'h1, 1'b1, 1'b1, 2'h0));
    prog(4'd1, mkw(3'd7, 4'd0, 3'h7, 3'h7, 3'h0, 3'h0, 4'h2, 1'b1, 1'b1, 2'h0));
    run(4'd0, -1);
    check("t1_done_cyc", done_cyc, 7);
    check("t1_exec0_cyc", alu_cyc[1], 2);
    check("t1_exec1_cyc", alu_cyc[2], 5);
    check("t1_err", sq.SC_MICROSEQUENCER_error_Out, 0);
    check("t1_pc", sq.SC_MICROSEQUENCER_pc_OutBUS, 1);

    // JZ at 2 -> 9 when zero flag asserted (line low), else falls to 3.
    prog(4'd2, mkw(3'd2, 4'd9, 3'h2, 3'h3, 3'h4, 3'h5, 4'h3, 1'b0, 1'b1, 2'h1));
    prog(4'd9, mkw(3'd7, 4'd0, 3'h7, 3'h7, 3'h0, 3'h0, 4'h4, 1'b1, 1'b0, 2'h2));
    prog(4'd3, mkw(3'd7, 4'd0, 3'h1, 3'h7, 3'h0, 3'h0, 4'h5, 1'b0, 1'b1, 2'h3));
    sq.SC_MICROSEQUENCER_zero_InLow = 1'b0;
    run(4'd2, -1);
    check("jz_taken_pc", sq.SC_MICROSEQUENCER_pc_OutBUS, 9);
    sq.SC_MICROSEQUENCER_zero_InLow = 1'b1;
    run(4'd2, -1);
    check("jz_fall_pc", sq.SC_MICROSEQUENCER_pc_OutBUS, 3);
    check("jz_fall_exec1", alu_cyc[5], 5);

    // Wrap 15 -> 0; word 0 is rewritten in the same cycle as start.
    prog(4'd15, mkw(3'd0, 4'd0, 3'h7, 3'h6, 3'h5, 3'h0, 4'h6, 1'b1, 1'b1, 2'h0));
    launch(4'd15, -1, 1'b1, 4'd0, mkw(3'd7, 4'd0, 3'h7, 3'h7, 3'h0, 3'h0, 4'h7, 1'b1, 1'b0, 2'h0));
    drain();
    check("wrap_pc", sq.SC_MICROSEQUENCER_pc_OutBUS, 0);
    check("wrap_new_word", alu_cyc[7], 5);

    // Watchdog: endless JMP 0 stops after MAX_STEPS executions.
    prog(4'd0, mkw(3'd1, 4'd0, 3'h7, 3'h7, 3'h0, 3'h0, 4'h8, 1'b1, 1'b1, 2'h0));
    run(4'd0, -1);
    check("wd_done_cyc", done_cyc, 16);
    check("wd_err", sq.SC_MICROSEQUENCER_error_Out, 1);

    // Abort during the first EXEC cycle.
    prog(4'd0, mkw(3'd0, 4'd0, 3'h7, 3'h0, 3'h1, 3'h2, 4'h1, 1'b1, 1'b1, 2'h0));
    run(4'd0, 1);
    check("ab_done_cyc", done_cyc, 3);
    check("ab_no_exec", alu_cyc[1], 0);
    check("ab_err", sq.SC_MICROSEQUENCER_error_Out, 1);
    sq.SC_MICROSEQUENCER_abort_In = 1'b1;
    tick();
    sq.SC_MICROSEQUENCER_abort_In = 1'b0;
    tick();
    check("ab_err_hold", sq.SC_MICROSEQUENCER_error_Out, 1);
    run(4'd0, -1);
    check("ab_err_clear", sq.SC_MICROSEQUENCER_error_Out, 0);

    // Writes and start requests while busy are ignored.
    launch(4'd0, -1, 1'b0, 4'd0, '0);
    tick();
    sq.SC_MICROSEQUENCER_progwrite_In    = 1'b1;
    sq.SC_MICROSEQUENCER_progaddr_InBUS  = 4'd0;
    sq.SC_MICROSEQUENCER_progdata_InBUS  = mkw(3'd7, 4'd0, 3'h7, 3'h7, 3'h0, 3'h0, 4'h9, 1'b1, 1'b1, 2'h0);
    sq.SC_MICROSEQUENCER_start_In        = 1'b1;
    sq.SC_MICROSEQUENCER_startaddr_InBUS = 4'd9;
    tick();
    sq.SC_MICROSEQUENCER_progwrite_In = 1'b0;
    sq.SC_MICROSEQUENCER_start_In     = 1'b0;
    drain();
    run(4'd0, -1);
    check("bw_old_word", alu_cyc[1], 2);
    check("bw_no_new", alu_cyc[9], 0);

    // Reset mid-run: back to idle, no done pulse, program retained.
    launch(4'd0, -1, 1'b0, 4'd0, '0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    idle_exp = {1'b0, 1'b0, 1'b0, 4'h0, CTRL_OFF};
    rst_n = 1'b1;
    repeat (6) tick();
    check("mr_no_done", done_seen, 0);
    check("mr_busy", sq.SC_MICROSEQUENCER_busy_Out, 0);
    check("mr_pc", sq.SC_MICROSEQUENCER_pc_OutBUS, 0);
    run(4'd0, -1);
    check("mr_mem_kept", alu_cyc[1], 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
